// File: rtl/vedic_mult_pipe.sv
// Three-stage Vedic (Urdhva-Tiryagbhyam) multiplier for signed or unsigned operands,
// with valid/ready handshaking; the whole pipeline stalls together while the output is held.
module vedic_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     tag_out
);

    localparam int HW = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    generate
        if ((WIDTH < 8) || (WIDTH > 32) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("vedic_mult_pipe: WIDTH must be even and within 8..32");
        end
    endgenerate

    // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1), which still fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sg);
        logic [WIDTH-1:0] m;
        if (sg && x[WIDTH-1]) begin
            m = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = x;
        end
        return m;
    endfunction

    logic               advance_s;
    logic               s1_valid_q, s1_valid_d, s1_neg_q, s1_neg_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
    logic [WIDTH-1:0]   s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    logic               s2_valid_q, s2_valid_d, s2_neg_q, s2_neg_d;
    logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;
    logic [WIDTH-1:0]   s2_ll_q, s2_ll_d, s2_hl_q, s2_hl_d;
    logic [WIDTH-1:0]   s2_lh_q, s2_lh_d, s2_hh_q, s2_hh_d;
    logic               out_valid_q, out_valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [PW-1:0]      result_q, result_d;
    logic [WIDTH:0]     mid_s;
    logic [PW-1:0]      sum_s;

    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_q;

    // S1: capture operands as magnitudes and record the sign of the product.
    always_comb begin
        if (advance_s) begin
            s1_valid_d = in_valid;
            s1_neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            s1_tag_d   = tag_in;
            s1_ma_d    = magnitude(a, is_signed);
            s1_mb_d    = magnitude(b, is_signed);
        end else begin
            s1_valid_d = s1_valid_q;
            s1_neg_d   = s1_neg_q;
            s1_tag_d   = s1_tag_q;
            s1_ma_d    = s1_ma_q;
            s1_mb_d    = s1_mb_q;
        end
    end

    // S2: the four half-width crosswise products.
    always_comb begin
        if (advance_s) begin
            s2_valid_d = s1_valid_q;
            s2_neg_d   = s1_neg_q;
            s2_tag_d   = s1_tag_q;
            s2_ll_d    = WIDTH'(s1_ma_q[HW-1:0])     * WIDTH'(s1_mb_q[HW-1:0]);
            s2_hl_d    = WIDTH'(s1_ma_q[WIDTH-1:HW]) * WIDTH'(s1_mb_q[HW-1:0]);
            s2_lh_d    = WIDTH'(s1_ma_q[HW-1:0])     * WIDTH'(s1_mb_q[WIDTH-1:HW]);
            s2_hh_d    = WIDTH'(s1_ma_q[WIDTH-1:HW]) * WIDTH'(s1_mb_q[WIDTH-1:HW]);
        end else begin
            s2_valid_d = s2_valid_q;
            s2_neg_d   = s2_neg_q;
            s2_tag_d   = s2_tag_q;
            s2_ll_d    = s2_ll_q;
            s2_hl_d    = s2_hl_q;
            s2_lh_d    = s2_lh_q;
            s2_hh_d    = s2_hh_q;
        end
    end

    // S3: recombine partial products; negating a zero sum yields zero again.
    always_comb begin
        mid_s = {1'b0, s2_hl_q} + {1'b0, s2_lh_q};
        sum_s = PW'(s2_ll_q) + (PW'(mid_s) << HW) + {s2_hh_q, {WIDTH{1'b0}}};
        if (advance_s) begin
            out_valid_d = s2_valid_q;
            tag_d       = s2_tag_q;
            if (s2_neg_q) begin
                result_d = ~sum_s + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                result_d = sum_s;
            end
        end else begin
            out_valid_d = out_valid_q;
            tag_d       = tag_q;
            result_d    = result_q;
        end
    end

    // Stage registers; reset clears every in-flight operation and the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_tag_q    <= {TAG_W{1'b0}};
            s1_ma_q     <= {WIDTH{1'b0}};
            s1_mb_q     <= {WIDTH{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_tag_q    <= {TAG_W{1'b0}};
            s2_ll_q     <= {WIDTH{1'b0}};
            s2_hl_q     <= {WIDTH{1'b0}};
            s2_lh_q     <= {WIDTH{1'b0}};
            s2_hh_q     <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            tag_q       <= {TAG_W{1'b0}};
            result_q    <= {PW{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_neg_q    <= s1_neg_d;
            s1_tag_q    <= s1_tag_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s2_valid_q  <= s2_valid_d;
            s2_neg_q    <= s2_neg_d;
            s2_tag_q    <= s2_tag_d;
            s2_ll_q     <= s2_ll_d;
            s2_hl_q     <= s2_hl_d;
            s2_lh_q     <= s2_lh_d;
            s2_hh_q     <= s2_hh_d;
            out_valid_q <= out_valid_d;
            tag_q       <= tag_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe: directed corner cases at WIDTH=16 plus
// random streams at WIDTH=8/16/32 checked against an arithmetic reference product.
module tb_vedic_mult_pipe;

    localparam int TAG_W    = 4;
    localparam int HALF_OPS = 10000;
    localparam int ALL_OPS  = 2 * HALF_OPS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  in_valid_s, out_ready_s, is_signed_s;
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    logic [3:0]  tag_s [3];
    logic        in_ready8, in_ready16, in_ready32, out_valid8, out_valid16, out_valid32;
    logic [15:0] res8;
    logic [31:0] res16;
    logic [63:0] res32;
    logic [3:0]  tago8, tago16, tago32;
    logic [2:0]  in_ready_s, out_valid_s, acc_s;
    logic [63:0] res_v [3];
    logic [3:0]  tago_v [3];

    int          wid [3] = '{8, 16, 32};
    int          total = 0;
    int          bad = 0;
    int          popped [3];
    int          nsent [3];
    logic [63:0] exp_res_q [3][$];
    logic [3:0]  exp_tag_q [3][$];

    vedic_mult_pipe #(.WIDTH(8), .TAG_W(TAG_W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready8),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .is_signed(is_signed_s[0]), .tag_in(tag_s[0]),
        .out_valid(out_valid8), .out_ready(out_ready_s[0]), .result(res8), .tag_out(tago8));
    vedic_mult_pipe #(.WIDTH(16), .TAG_W(TAG_W)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready16),
        .a(a_s[1][15:0]), .b(b_s[1][15:0]), .is_signed(is_signed_s[1]), .tag_in(tag_s[1]),
        .out_valid(out_valid16), .out_ready(out_ready_s[1]), .result(res16), .tag_out(tago16));
    vedic_mult_pipe #(.WIDTH(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready32),
        .a(a_s[2]), .b(b_s[2]), .is_signed(is_signed_s[2]), .tag_in(tag_s[2]),
        .out_valid(out_valid32), .out_ready(out_ready_s[2]), .result(res32), .tag_out(tago32));

    always_comb begin
        in_ready_s  = {in_ready32, in_ready16, in_ready8};
        out_valid_s = {out_valid32, out_valid16, out_valid8};
        res_v[0]    = {48'd0, res8};
        res_v[1]    = {32'd0, res16};
        res_v[2]    = res32;
        tago_v[0]   = tago8;
        tago_v[1]   = tago16;
        tago_v[2]   = tago32;
    end

    // Reference: the true product of the interpreted operands, kept modulo 2^(2w).
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] x,
                                             input logic [31:0] y, input logic sg);
        longint      sx, sy;
        logic [63:0] p, mask;
        mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        if (sg) begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
            if (x[w-1]) sx = sx - (longint'(1) << w);
            if (y[w-1]) sy = sy - (longint'(1) << w);
            p = 64'(sx * sy);
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        return p & mask;
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score outputs and accepted inputs, return #1 after the rising edge.
    task automatic step_cycle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            acc_s[k] = in_valid_s[k] && in_ready_s[k];
            if (out_valid_s[k]) begin
                if (exp_res_q[k].size() == 0) begin
                    chk($sformatf("spurious_w%0d", wid[k]), 64'(out_valid_s[k]), 64'd0);
                end else begin
                    chk($sformatf("result_w%0d", wid[k]), res_v[k], exp_res_q[k][0]);
                    chk($sformatf("tag_w%0d", wid[k]), 64'(tago_v[k]), 64'(exp_tag_q[k][0]));
                    if (out_ready_s[k]) begin
                        void'(exp_res_q[k].pop_front());
                        void'(exp_tag_q[k].pop_front());
                        popped[k]++;
                    end
                end
            end
            if (acc_s[k]) begin
                exp_res_q[k].push_back(ref_prod(wid[k], a_s[k], b_s[k], is_signed_s[k]));
                exp_tag_q[k].push_back(tag_s[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single operation on the 16-bit instance with a known product and latency.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic sg,
                         input logic [3:0] tg, input logic [31:0] exp, input string nm);
        int lat;
        a_s[1] = {16'd0, x};
        b_s[1] = {16'd0, y};
        is_signed_s[1] = sg;
        tag_s[1] = tg;
        in_valid_s[1] = 1'b1;
        out_ready_s[1] = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, 64'(in_ready_s[1]), 64'd1);
        @(posedge clk);
        #1 in_valid_s[1] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 6 && lat == 0; n++) begin
            @(negedge clk);
            if (out_valid_s[1]) lat = n;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd3);
        chk({nm, "_result"}, res_v[1], {32'd0, exp});
        chk({nm, "_tag"}, 64'(tago_v[1]), 64'(tg));
        @(negedge clk);
        chk({nm, "_pulse"}, 64'(out_valid_s[1]), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic gen_op(input int k);
        logic [31:0] mask;
        logic [31:0] v [2];
        int          w;
        w = wid[k];
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int i = 0; i < 2; i++) begin
            case ($urandom_range(7, 0))
                0:       v[i] = 32'd0;
                1:       v[i] = 32'hFFFF_FFFF;
                2:       v[i] = 32'd1 << (w - 1);
                3:       v[i] = (32'd1 << (w - 1)) - 32'd1;
                default: v[i] = $urandom;
            endcase
        end
        a_s[k] = v[0] & mask;
        b_s[k] = v[1] & mask;
        is_signed_s[k] = (nsent[k] >= HALF_OPS);
        tag_s[k] = 4'($urandom);
        in_valid_s[k] = 1'b1;
    endtask

    initial begin
        int  sent;
        logic need;
        rst_n = 1'b0;
        in_valid_s = 3'b000;
        out_ready_s = 3'b000;
        is_signed_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            a_s[k] = 32'd0; b_s[k] = 32'd0; tag_s[k] = 4'd0; popped[k] = 0; nsent[k] = 0;
        end

        // Reset state, before and after clock edges while held low.
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid_w%0d", wid[k]), 64'(out_valid_s[k]), 64'd0);
            chk($sformatf("rst_result_w%0d", wid[k]), res_v[k], 64'd0);
            chk($sformatf("rst_tag_w%0d", wid[k]), 64'(tago_v[k]), 64'd0);
            chk($sformatf("rst_in_ready_w%0d", wid[k]), 64'(in_ready_s[k]), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_out_valid", 64'(out_valid_s[1]), 64'd0);
        rst_n = 1'b1;
        out_ready_s = 3'b111;
        @(posedge clk);
        #1;

        // Directed products at WIDTH=16.
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 4'd3, 32'hFFFE_0001, "u_ffff_sq");
        do_op(16'hFFFD, 16'h0005, 1'b1, 4'd5, 32'hFFFF_FFF1, "s_m3x5");
        do_op(16'hFFFD, 16'h0005, 1'b0, 4'd6, 32'h0004_FFF1, "u_fffdx5");
        do_op(16'h8000, 16'h8000, 1'b1, 4'd7, 32'h4000_0000, "s_min_sq");
        do_op(16'h8000, 16'h7FFF, 1'b1, 4'd8, 32'hC000_8000, "s_minxmax");
        do_op(16'h8000, 16'hFFFF, 1'b1, 4'd9, 32'h0000_8000, "s_minxm1");
        do_op(16'h0000, 16'hFFFB, 1'b1, 4'd10, 32'h0000_0000, "s_zero_neg");

        // Back-to-back stream of 8 with a 4-cycle output stall mid-stream.
        sent = 0;
        need = 1'b1;
        popped[1] = 0;
        for (int c = 0; c < 60 && (sent < 8 || exp_res_q[1].size() != 0); c++) begin
            if (sent < 8 && need) begin
                a_s[1] = 32'($urandom_range(65535, 0));
                b_s[1] = 32'($urandom_range(65535, 0));
                is_signed_s[1] = 1'($urandom_range(1, 0));
                tag_s[1] = 4'(sent);
                need = 1'b0;
            end
            in_valid_s[1] = (sent < 8);
            out_ready_s[1] = !(c >= 4 && c < 8);
            #1;
            if (c >= 4 && c < 8) chk("stall_in_ready", 64'(in_ready_s[1]), 64'd0);
            step_cycle();
            if (acc_s[1]) begin
                sent++;
                need = 1'b1;
            end
        end
        in_valid_s[1] = 1'b0;
        out_ready_s[1] = 1'b1;
        chk("stream_accepted", 64'(sent), 64'd8);
        chk("stream_delivered", 64'(popped[1]), 64'd8);
        chk("stream_drained", 64'(exp_res_q[1].size()), 64'd0);

        // Reset with two operations in flight, one already presented at the output.
        out_ready_s[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_s[1] = 32'(16'h1234 + i);
            b_s[1] = 32'd3;
            is_signed_s[1] = 1'b0;
            tag_s[1] = 4'(11 + i);
            in_valid_s[1] = 1'b1;
            step_cycle();
        end
        in_valid_s[1] = 1'b0;
        step_cycle();
        chk("inflight_out_valid", 64'(out_valid_s[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid_s[1]), 64'd0);
        chk("midrst_result", res_v[1], 64'd0);
        chk("midrst_tag", 64'(tago_v[1]), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_s[1]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            exp_res_q[k].delete();
            exp_tag_q[k].delete();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready_s[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("postrst_quiet", 64'(out_valid_s[1]), 64'd0);
            step_cycle();
        end
        do_op(16'h0100, 16'h0020, 1'b0, 4'd14, 32'h0000_2000, "postrst_op");

        // Random streams on all widths: unsigned first, then signed, with random stalls.
        for (int k = 0; k < 3; k++) begin
            nsent[k] = 0;
            popped[k] = 0;
        end
        in_valid_s = 3'b000;
        for (int c = 0; c < 70000; c++) begin
            if (nsent[0] == ALL_OPS && nsent[1] == ALL_OPS && nsent[2] == ALL_OPS &&
                exp_res_q[0].size() == 0 && exp_res_q[1].size() == 0 &&
                exp_res_q[2].size() == 0) break;
            for (int k = 0; k < 3; k++) begin
                out_ready_s[k] = ($urandom_range(9, 0) != 0);
                if (nsent[k] < ALL_OPS && !in_valid_s[k] && $urandom_range(9, 0) != 0) gen_op(k);
            end
            step_cycle();
            for (int k = 0; k < 3; k++) begin
                if (acc_s[k]) begin
                    nsent[k]++;
                    in_valid_s[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rand_sent_w%0d", wid[k]), 64'(nsent[k]), 64'(ALL_OPS));
            chk($sformatf("rand_recv_w%0d", wid[k]), 64'(popped[k]), 64'(ALL_OPS));
            chk($sformatf("rand_drained_w%0d", wid[k]), 64'(exp_res_q[k].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
